// File: rtl/fifo_stream_adapter_if.sv
// Read-side FIFO port plus downstream valid/ready stream seen by fifo_stream_adapter.
// master = adapter side, slave = FIFO/consumer side.
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  flit_count;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_valid, flit_count
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_valid, flit_count
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Absorbs the attached FIFO's one-cycle read latency into a 2-entry queue and
// presents flits on a bubble-free valid/ready stream, counting completed transfers.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_adapter_if.master bus
);
  logic [DATA_WIDTH-1:0] q_q [2];
  logic                  hd_q, hd_d;
  logic                  tl_q, tl_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  flit_count_q, flit_count_d;

  logic       pop;
  logic [2:0] level_after;
  logic       rd_en;

  assign pop = (cnt_q != 2'd0) & bus.out_ready;

  // Occupancy the queue will hold once this cycle's capture and pop settle;
  // a new read is only safe if it still leaves room for its data next cycle.
  assign level_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en       = rst_n & ~bus.fifo_empty & (level_after < 3'd2);

  always_comb begin
    inflight_d   = rd_en;
    tl_d         = inflight_q ? ~tl_q : tl_q;
    hd_d         = pop ? ~hd_q : hd_q;
    cnt_d        = level_after[1:0];
    flit_count_d = pop ? flit_count_q + CNT_WIDTH'(1) : flit_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_q         <= 1'b0;
      tl_q         <= 1'b0;
      inflight_q   <= 1'b0;
      cnt_q        <= 2'd0;
      flit_count_q <= '0;
    end else begin
      hd_q         <= hd_d;
      tl_q         <= tl_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      flit_count_q <= flit_count_d;
    end
  end

  // Queue storage needs no reset: out_valid gates every entry.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (inflight_q && (tl_q == 1'(gi))) begin
        q_q[gi] <= bus.fifo_dout;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (cnt_q != 2'd0);
  assign bus.out_data   = q_q[hd_q];
  assign bus.flit_count = flit_count_q;

`ifdef debug
  always_ff @(posedge clk) begin
    if (rst_n && (({1'b0, cnt_q} + {2'b00, inflight_q}) > 3'd2)) begin
      $display("fifo_stream_adapter: occupancy overflow cnt=%0d inflight=%0d", cnt_q, inflight_q);
    end
  end
`endif
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: behavioural FIFO, in-order scoreboard, table-driven
// random runs and hand-written reset/stall/boundary sequences.
module tb_fifo_stream_adapter;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fifo_rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_adapter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural FIFO with registered empty flag and one-cycle read data.
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem [256];
  int unsigned   wptr, rptr;

  always @(posedge clk or negedge fifo_rst_n) begin : fifo_model
    int unsigned w, r;
    if (!fifo_rst_n) begin
      wptr <= 0;
      rptr <= 0;
      bus.fifo_empty <= 1'b1;
    end else begin
      w = wptr;
      r = rptr;
      if (wr_en) begin
        mem[w % 256] <= wr_data;
        w = w + 1;
      end
      if (bus.fifo_rd_en && (rptr != wptr)) begin
        bus.fifo_dout <= mem[r % 256];
        r = r + 1;
      end
      wptr <= w;
      rptr <= r;
      bus.fifo_empty <= (w == r);
    end
  end

  // Scoreboard: every flit written must leave the stream exactly once, in order.
  logic [DW-1:0] exp_q [$];
  int unsigned   mon_reads, mon_xfers;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  int            outst;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_reads  = 0;
      mon_xfers  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(prev_data));
      end
      check("flit_count", 64'(bus.flit_count), 64'(mon_xfers[15:0]));
      outst = int'(mon_reads) - int'(mon_xfers);
      check("outstanding_le2", 64'(outst <= 2), 64'd1);
      if (bus.fifo_rd_en) check("rd_nonempty", 64'(rptr != wptr), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL data: got %0h expected nothing (no flit pending)", bus.out_data);
        end else begin
          check("data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        end
        mon_xfers++;
      end
      if (bus.fifo_rd_en) mon_reads++;
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int n;
    int ready_pct;
    int push_pct;
    int exp_xfers;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int first, last, nv, nr, rem, cyc;
    int unsigned r0, x0;

    vecs[0] = '{n: 10, ready_pct: 100, push_pct: 100, exp_xfers: 10};
    vecs[1] = '{n: 25, ready_pct: 50,  push_pct: 70,  exp_xfers: 25};
    vecs[2] = '{n: 30, ready_pct: 20,  push_pct: 100, exp_xfers: 30};
    vecs[3] = '{n: 40, ready_pct: 90,  push_pct: 30,  exp_xfers: 40};

    bus.out_ready = 1'b0;
    repeat (3) step();
    fifo_rst_n = 1'b1;

    // Reset with FIFO pre-loaded
    for (int i = 0; i < 3; i++) push_one(DW'(32'h100 + i));
    step();
    step();
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.flit_count), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    step();
    check("rel_valid_n1", 64'(bus.out_valid), 64'd0);
    step();
    check("rel_valid_n2", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    drain(50);
    check("rst_flits", 64'(bus.flit_count), 64'd3);

    // Streaming 0x1..0x10 with ready held high
    first = -1; last = -1; nv = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        wr_en   = 1'b1;
        wr_data = DW'(c + 1);
        exp_q.push_back(DW'(c + 1));
      end else begin
        wr_en = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      step();
    end
    wr_en = 1'b0;
    check("stream_n", 64'(nv), 64'd16);
    check("stream_span", 64'(last - first), 64'd15);
    check("stream_count", 64'(bus.flit_count), 64'd19);

    // Stall: 8 flits queued behind ready=0
    bus.out_ready = 1'b0;
    r0 = mon_reads;
    for (int i = 1; i <= 8; i++) push_one(DW'(i));
    repeat (10) step();
    check("stall_reads", 64'(mon_reads - r0), 64'd2);
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    check("stall_head", 64'(bus.out_data), 64'd1);
    bus.out_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) nv++;
      step();
    end
    check("stall_burst", 64'(nv), 64'd8);
    drain(20);

    // Toggling ready over 20 flits
    rem = 20; cyc = 0;
    while ((rem > 0 || exp_q.size() != 0) && cyc < 200) begin
      bus.out_ready = cyc[0];
      if (rem > 0) begin
        wr_en   = 1'b1;
        wr_data = DW'(32'h200 + rem);
        exp_q.push_back(DW'(32'h200 + rem));
        rem--;
      end else begin
        wr_en = 1'b0;
      end
      step();
      cyc++;
    end
    wr_en = 1'b0;
    check("toggle_done", 64'(exp_q.size()), 64'd0);
    check("toggle_count", 64'(bus.flit_count), 64'd47);

    // Empty boundary: a single flit
    bus.out_ready = 1'b1;
    r0 = mon_reads;
    x0 = mon_xfers;
    push_one(DW'(32'hA5));
    repeat (6) step();
    check("single_reads", 64'(mon_reads - r0), 64'd1);
    check("single_xfers", 64'(mon_xfers - x0), 64'd1);
    check("single_idle_valid", 64'(bus.out_valid), 64'd0);
    check("single_idle_rd", 64'(bus.fifo_rd_en), 64'd0);
    check("single_count", 64'(bus.flit_count), 64'd48);

    // Table-driven random traffic
    for (int v = 0; v < 4; v++) begin
      x0 = mon_xfers;
      rem = vecs[v].n;
      cyc = 0;
      while ((rem > 0 || exp_q.size() != 0) && cyc < 2000) begin
        bus.out_ready = ($urandom_range(99) < 32'(vecs[v].ready_pct));
        if (rem > 0 && $urandom_range(99) < 32'(vecs[v].push_pct)) begin
          wr_en   = 1'b1;
          wr_data = DW'($urandom);
          exp_q.push_back(wr_data);
          rem--;
        end else begin
          wr_en = 1'b0;
        end
        step();
        cyc++;
      end
      wr_en = 1'b0;
      check("tbl_xfers", 64'(mon_xfers - x0), 64'(vecs[v].exp_xfers));
      check("tbl_idle", 64'(bus.out_valid), 64'd0);
    end
    check("tbl_count", 64'(bus.flit_count), 64'd153);

    // Mid-stream reset with a full queue
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(DW'(32'h300 + i));
    repeat (2) step();
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    fifo_rst_n = 1'b0;
    #1;
    check("async_valid", 64'(bus.out_valid), 64'd0);
    check("async_count", 64'(bus.flit_count), 64'd0);
    check("async_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    fifo_rst_n = 1'b1;
    bus.out_ready = 1'b1;
    nv = 0; nr = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) nv++;
      if (bus.fifo_rd_en) nr++;
      step();
    end
    check("post_rst_valid", 64'(nv), 64'd0);
    check("post_rst_reads", 64'(nr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
